// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if
// Bundle between the multi-cycle control FSM and the rest of the core.
//   master (control FSM):    drives fetch request, PC, register indices,
//                            datapath controls, immediate and halt.
//   slave  (datapath/imem):  drives instruction word/valid, ALU zero flag
//                            and register-file port-1 read data.
// Signals:
//   instr[31:0]      instruction word from instruction memory
//   instr_valid      instr is valid this cycle
//   instr_req        fetch request for address PC
//   PC[31:0]         current program counter
//   eq               ALU zero flag
//   rd1              register-file port-1 read data
//   rs1/rs2/rd       register indices
//   RegWrite, ALUSrc, ResultSrc, MemWrite, jalmuxSel, ALUCtrl[2:0]
//                    datapath controls
//   ImmOp            sign-extended immediate
//   halt             core stopped on an illegal instruction
// -----------------------------------------------------------------------------
interface control_fsm_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic [31:0]              instr;
  logic                     instr_valid;
  logic                     instr_req;
  logic [31:0]              PC;
  logic                     eq;
  logic [DATA_WIDTH-1:0]    rd1;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     RegWrite;
  logic                     ALUSrc;
  logic                     ResultSrc;
  logic                     MemWrite;
  logic                     jalmuxSel;
  logic [2:0]               ALUCtrl;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     halt;

  modport master (
    input  instr, instr_valid, eq, rd1,
    output instr_req, PC, rs1, rs2, rd, RegWrite, ALUSrc, ResultSrc,
           MemWrite, jalmuxSel, ALUCtrl, ImmOp, halt
  );

  modport slave (
    output instr, instr_valid, eq, rd1,
    input  instr_req, PC, rs1, rs2, rd, RegWrite, ALUSrc, ResultSrc,
           MemWrite, jalmuxSel, ALUCtrl, ImmOp, halt
  );
endinterface

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Multi-cycle control unit for a small RV32I subset
// (add sub and or slt addi lw sw beq bne jal jalr).
// State walk: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH; any
// unsupported encoding parks the core in HALT until reset.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    control_fsm_if.master (fetch handshake, PC, indices, controls)
// All outputs are registered.
// -----------------------------------------------------------------------------
module control_fsm #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_WIDTH = 5,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  control_fsm_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR} kind_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e                   state;
  kind_e                    kind_q;
  logic                     bne_q;
  logic [31:0]              ir;
  logic [31:0]              pc_q;
  logic [31:0]              target_q;
  logic                     instr_req_q;
  logic [ADDRESS_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                     regwrite_q, alusrc_q, resultsrc_q, memwrite_q, jalmux_q;
  logic [2:0]               aluctrl_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic                     halt_q;

  // ---------------------------------------------------------------------------
  // Instruction field extraction and immediate formats
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Decode of IR, consumed only in the DECODE state
  // ---------------------------------------------------------------------------
  kind_e       dec_kind;
  logic        dec_legal, dec_bne, dec_alusrc;
  logic [2:0]  dec_alu;
  logic [31:0] dec_imm;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    dec_kind   = K_ALU;
    dec_legal  = 1'b0;
    dec_bne    = 1'b0;
    dec_alusrc = 1'b0;
    dec_alu    = ALU_ADD;
    dec_imm    = '0;
    case (opcode)
      OP_R: begin
        dec_legal = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_alu = ALU_ADD;
          {7'b0100000, 3'b000}: dec_alu = ALU_SUB;
          {7'b0000000, 3'b111}: dec_alu = ALU_AND;
          {7'b0000000, 3'b110}: dec_alu = ALU_OR;
          {7'b0000000, 3'b010}: dec_alu = ALU_SLT;
          default:              dec_legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec_legal  = (funct3 == 3'b000);
        dec_alusrc = 1'b1;
        dec_imm    = imm_i;
      end
      OP_LOAD: begin
        dec_legal  = (funct3 == 3'b010);
        dec_kind   = K_LOAD;
        dec_alusrc = 1'b1;
        dec_imm    = imm_i;
      end
      OP_STORE: begin
        dec_legal  = (funct3 == 3'b010);
        dec_kind   = K_STORE;
        dec_alusrc = 1'b1;
        dec_imm    = imm_s;
      end
      OP_BRANCH: begin
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec_kind  = K_BRANCH;
        dec_bne   = funct3[0];
        dec_alu   = ALU_SUB;
        dec_imm   = imm_b;
      end
      OP_JAL: begin
        dec_legal = 1'b1;
        dec_kind  = K_JAL;
        dec_imm   = imm_j;
      end
      OP_JALR: begin
        dec_legal  = (funct3 == 3'b000);
        dec_kind   = K_JALR;
        dec_alusrc = 1'b1;
        dec_imm    = imm_i;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC arithmetic (32-bit, wraps silently)
  // ---------------------------------------------------------------------------
  logic [31:0] imm32, pc_plus4, pc_plus_imm, jalr_sum, jalr_tgt;
  logic        rd_nz, taken;

  assign imm32       = 32'(signed'(imm_q));
  assign pc_plus4    = pc_q + 32'd4;
  assign pc_plus_imm = pc_q + imm32;
  assign jalr_sum    = 32'(bus.rd1) + imm32;
  assign jalr_tgt    = jalr_sum & ~32'd1;
  assign rd_nz       = (rd_q != '0);
  assign taken       = bne_q ? ~bus.eq : bus.eq;

  // ---------------------------------------------------------------------------
  // State machine with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      kind_q      <= K_ALU;
      bne_q       <= 1'b0;
      // NOTE: IR is a single register, not a memory array, so it is cleared
      // by reset like all other state.
      ir          <= '0;
      pc_q        <= RESET_PC;
      target_q    <= '0;
      // The fetch request mirrors "state == FETCH", so it comes out of reset
      // asserted and the first cycle after release already requests.
      instr_req_q <= 1'b1;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      resultsrc_q <= 1'b0;
      memwrite_q  <= 1'b0;
      jalmux_q    <= 1'b0;
      aluctrl_q   <= ALU_ADD;
      imm_q       <= '0;
      halt_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir          <= bus.instr;
            instr_req_q <= 1'b0;
            state       <= DECODE;
          end
        end

        DECODE: begin
          if (dec_legal) begin
            rs1_q     <= ADDRESS_WIDTH'(ir[19:15]);
            rs2_q     <= ADDRESS_WIDTH'(ir[24:20]);
            rd_q      <= ADDRESS_WIDTH'(ir[11:7]);
            imm_q     <= DATA_WIDTH'(signed'(dec_imm));
            aluctrl_q <= dec_alu;
            alusrc_q  <= dec_alusrc;
            kind_q    <= dec_kind;
            bne_q     <= dec_bne;
            state     <= EXEC;
          end else begin
            halt_q <= 1'b1;
            state  <= HALT;
          end
        end

        EXEC: begin
          case (kind_q)
            K_ALU: begin
              regwrite_q <= rd_nz;
              state      <= WB;
            end
            K_LOAD: begin
              resultsrc_q <= 1'b1;
              state       <= MEM;
            end
            K_STORE: begin
              memwrite_q <= 1'b1;
              state      <= MEM;
            end
            K_BRANCH: begin
              pc_q        <= taken ? pc_plus_imm : pc_plus4;
              instr_req_q <= 1'b1;
              state       <= FETCH;
            end
            K_JAL, K_JALR: begin
              // Target is captured now; PC itself holds through WB so the
              // datapath can form the link value old PC + 4.
              target_q   <= (kind_q == K_JAL) ? pc_plus_imm : jalr_tgt;
              jalmux_q   <= 1'b1;
              regwrite_q <= rd_nz;
              state      <= WB;
            end
            default: begin
              halt_q <= 1'b1;
              state  <= HALT;
            end
          endcase
        end

        MEM: begin
          if (kind_q == K_LOAD) begin
            regwrite_q <= rd_nz;
            state      <= WB;
          end else begin
            memwrite_q  <= 1'b0;
            pc_q        <= pc_plus4;
            instr_req_q <= 1'b1;
            state       <= FETCH;
          end
        end

        WB: begin
          regwrite_q  <= 1'b0;
          resultsrc_q <= 1'b0;
          jalmux_q    <= 1'b0;
          pc_q        <= (kind_q == K_JAL || kind_q == K_JALR) ? target_q : pc_plus4;
          instr_req_q <= 1'b1;
          state       <= FETCH;
        end

        HALT: ; // absorbing until reset

        default: begin
          halt_q <= 1'b1;
          state  <= HALT;
        end
      endcase
    end
  end

  assign bus.instr_req = instr_req_q;
  assign bus.PC        = pc_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.rd        = rd_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.ALUSrc    = alusrc_q;
  assign bus.ResultSrc = resultsrc_q;
  assign bus.MemWrite  = memwrite_q;
  assign bus.jalmuxSel = jalmux_q;
  assign bus.ALUCtrl   = aluctrl_q;
  assign bus.ImmOp     = imm_q;
  assign bus.halt      = halt_q;

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
// Directed bench for control_fsm: a straight-line program walking every
// instruction class, branch taken/not-taken, jal/jalr, PC wrap, illegal
// opcode halt, and asynchronous reset from HALT and from a stalled FETCH.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_control_fsm;
  localparam int          DW     = 32;
  localparam int          AW     = 5;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  control_fsm_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  control_fsm #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .RESET_PC      (RST_PC)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from FETCH and follow it until the next fetch
  // request. Per-cycle enables are collected as bit masks indexed by cycle
  // number (1 = FETCH cycle carrying instr_valid).
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input logic [31:0] pc_exp, input int cyc_exp,
                           input logic [7:0] rw_exp, input logic [7:0] mw_exp,
                           input logic [7:0] rs_exp, input logic [7:0] jm_exp,
                           input logic [31:0] pc_next);
    logic [7:0] rw_m, mw_m, rs_m, jm_m;
    int         c;
    bit         done, pc_moved;
    rw_m = '0; mw_m = '0; rs_m = '0; jm_m = '0;
    done = 1'b0; pc_moved = 1'b0;
    check({tag, ".req"}, 32'(bus.instr_req), 32'd1);
    check({tag, ".pc"}, bus.PC, pc_exp);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    c = 1;
    rw_m[1] = bus.RegWrite; mw_m[1] = bus.MemWrite;
    rs_m[1] = bus.ResultSrc; jm_m[1] = bus.jalmuxSel;
    tick();
    // Garbage on the bus afterwards: IR must have been latched already.
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hFFFF_FFFF;
    for (int i = 0; i < 6 && !done; i++) begin
      if (bus.instr_req) begin
        done = 1'b1;
      end else begin
        c++;
        rw_m[3'(c)] = bus.RegWrite;  mw_m[3'(c)] = bus.MemWrite;
        rs_m[3'(c)] = bus.ResultSrc; jm_m[3'(c)] = bus.jalmuxSel;
        if (bus.PC !== pc_exp) pc_moved = 1'b1;
        tick();
      end
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".cycles"}, 32'(c), 32'(cyc_exp));
    check({tag, ".pc_held"}, 32'(pc_moved), 32'd0);
    check({tag, ".RegWrite"}, 32'(rw_m), 32'(rw_exp));
    check({tag, ".MemWrite"}, 32'(mw_m), 32'(mw_exp));
    check({tag, ".ResultSrc"}, 32'(rs_m), 32'(rs_exp));
    check({tag, ".jalmuxSel"}, 32'(jm_m), 32'(jm_exp));
    check({tag, ".pc_next"}, bus.PC, pc_next);
  endtask

  localparam logic [31:0] I_ADDI   = 32'h0070_0293; // addi x5,x0,7
  localparam logic [31:0] I_ADD    = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] I_SW     = 32'h0060_2423; // sw   x6,8(x0)
  localparam logic [31:0] I_LW     = 32'h0080_2383; // lw   x7,8(x0)
  localparam logic [31:0] I_JAL16  = 32'h0100_006F; // jal  x0,+16
  localparam logic [31:0] I_JAL8   = 32'h0080_006F; // jal  x0,+8
  localparam logic [31:0] I_JAL28  = 32'h01C0_006F; // jal  x0,+28
  localparam logic [31:0] I_BEQ    = 32'hFE20_8CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_JALR   = 32'h0031_00E7; // jalr x1,x2,3
  localparam logic [31:0] I_JALR0  = 32'h0001_0067; // jalr x0,x2,0
  localparam logic [31:0] I_ILL    = 32'h0000_007F; // opcode 7'b1111111

  initial begin
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.eq          = 1'b0;
    bus.rd1         = '0;

    // Reset state, observed while rst_n is still low.
    #12;
    check("rst.pc", bus.PC, RST_PC);
    check("rst.halt", 32'(bus.halt), 32'd0);
    check("rst.RegWrite", 32'(bus.RegWrite), 32'd0);
    check("rst.ImmOp", bus.ImmOp, 32'd0);
    check("rst.rd", 32'(bus.rd), 32'd0);
    check("rst.ALUCtrl", 32'(bus.ALUCtrl), 32'd0);
    check("rst.ALUSrc", 32'(bus.ALUSrc), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU pair: 4 cycles each, one RegWrite pulse in WB, PC 0 -> 4 -> 8.
    run_instr("addi", I_ADDI, 32'h0, 4, 8'h10, 8'h00, 8'h00, 8'h00, 32'h4);
    check("addi.rd", 32'(bus.rd), 32'd5);
    check("addi.imm", bus.ImmOp, 32'd7);
    check("addi.alusrc", 32'(bus.ALUSrc), 32'd1);
    check("addi.aluctrl", 32'(bus.ALUCtrl), 32'd0);
    run_instr("add", I_ADD, 32'h4, 4, 8'h10, 8'h00, 8'h00, 8'h00, 32'h8);
    check("add.rs1", 32'(bus.rs1), 32'd5);
    check("add.rs2", 32'(bus.rs2), 32'd5);
    check("add.rd", 32'(bus.rd), 32'd6);
    check("add.imm", bus.ImmOp, 32'd0);
    check("add.alusrc", 32'(bus.ALUSrc), 32'd0);

    // Store then load.
    run_instr("sw", I_SW, 32'h8, 4, 8'h00, 8'h10, 8'h00, 8'h00, 32'hC);
    check("sw.imm", bus.ImmOp, 32'd8);
    check("sw.alusrc", 32'(bus.ALUSrc), 32'd1);
    run_instr("lw", I_LW, 32'hC, 5, 8'h20, 8'h00, 8'h30, 8'h00, 32'h10);

    // jal with rd=x0: link write suppressed.
    run_instr("jal16", I_JAL16, 32'h10, 4, 8'h00, 8'h00, 8'h00, 8'h10, 32'h20);
    check("jal16.imm", bus.ImmOp, 32'd16);

    // beq -8 at 0x20: taken, then back to 0x20 and not taken.
    bus.eq = 1'b1;
    run_instr("beq_t", I_BEQ, 32'h20, 3, 8'h00, 8'h00, 8'h00, 8'h00, 32'h18);
    check("beq.imm", bus.ImmOp, 32'hFFFF_FFF8);
    check("beq.aluctrl", 32'(bus.ALUCtrl), 32'd1);
    check("beq.alusrc", 32'(bus.ALUSrc), 32'd0);
    bus.eq = 1'b0;
    run_instr("jal8", I_JAL8, 32'h18, 4, 8'h00, 8'h00, 8'h00, 8'h10, 32'h20);
    run_instr("beq_nt", I_BEQ, 32'h20, 3, 8'h00, 8'h00, 8'h00, 8'h00, 32'h24);
    run_instr("jal28", I_JAL28, 32'h24, 4, 8'h00, 8'h00, 8'h00, 8'h10, 32'h40);

    // jalr x1,x2,3 with rd1=0x100: target (0x103)&~1 = 0x102.
    bus.rd1 = 32'h0000_0100;
    run_instr("jalr", I_JALR, 32'h40, 4, 8'h10, 8'h00, 8'h00, 8'h10, 32'h102);
    check("jalr.imm", bus.ImmOp, 32'd3);
    check("jalr.rs1", 32'(bus.rs1), 32'd2);
    check("jalr.rd", 32'(bus.rd), 32'd1);
    check("jalr.alusrc", 32'(bus.ALUSrc), 32'd1);

    // Jump to the top of the address space, then wrap to 0.
    bus.rd1 = 32'hFFFF_FFFC;
    run_instr("jalr0", I_JALR0, 32'h102, 4, 8'h00, 8'h00, 8'h00, 8'h10, 32'hFFFF_FFFC);
    run_instr("wrap", I_ADDI, 32'hFFFF_FFFC, 4, 8'h10, 8'h00, 8'h00, 8'h00, 32'h0);
    run_instr("addi2", I_ADDI, 32'h0, 4, 8'h10, 8'h00, 8'h00, 8'h00, 32'h4);

    // Illegal opcode at PC=4: HALT is absorbing, instr_valid ignored.
    check("ill.req", 32'(bus.instr_req), 32'd1);
    bus.instr       = I_ILL;
    bus.instr_valid = 1'b1;
    tick();
    check("ill.decode_halt", 32'(bus.halt), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("halt.halt", 32'(bus.halt), 32'd1);
      check("halt.req", 32'(bus.instr_req), 32'd0);
      check("halt.pc", bus.PC, 32'h4);
      check("halt.we", {30'd0, bus.RegWrite, bus.MemWrite}, 32'd0);
      tick();
    end
    bus.instr_valid = 1'b0;

    // Reset out of HALT (asynchronous: no clock edge before the checks).
    rst_n = 1'b0;
    #2;
    check("rst_halt.pc", bus.PC, RST_PC);
    check("rst_halt.halt", 32'(bus.halt), 32'd0);
    rst_n = 1'b1;
    check("rst_halt.req", 32'(bus.instr_req), 32'd1);
    tick();
    run_instr("after_halt", I_ADDI, 32'h0, 4, 8'h10, 8'h00, 8'h00, 8'h00, 32'h4);

    // Stall in FETCH at PC=4, then reset mid-fetch.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.req", 32'(bus.instr_req), 32'd1);
      check("stall.pc", bus.PC, 32'h4);
    end
    rst_n = 1'b0;
    #2;
    check("rst_fetch.pc", bus.PC, RST_PC);
    check("rst_fetch.rd", 32'(bus.rd), 32'd0);
    check("rst_fetch.imm", bus.ImmOp, 32'd0);
    rst_n = 1'b1;
    tick();
    run_instr("restart", I_ADDI, RST_PC, 4, 8'h10, 8'h00, 8'h00, 8'h00, 32'h4);
    check("restart.rd", 32'(bus.rd), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so a hung DUT still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
